// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: two in-order skid queues (ALU, LSU) feeding one registered broadcast.
// Define CDB_ROUND_ROBIN_EN for alternating grants under contention; otherwise LSU has fixed priority.
module cdb_arbiter #(
    parameter int ROB_W  = 4,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              rollback_in,
    input  logic              alu_valid_in,
    input  logic [ROB_W-1:0]  alu_rob_id_in,
    input  logic [DATA_W-1:0] alu_result_in,
    output logic              alu_ready_out,
    input  logic              lsu_valid_in,
    input  logic [ROB_W-1:0]  lsu_rob_id_in,
    input  logic [DATA_W-1:0] lsu_result_in,
    output logic              lsu_ready_out,
    output logic              cdb_valid_out,
    output logic [ROB_W-1:0]  cdb_rob_id_out,
    output logic [DATA_W-1:0] cdb_result_out,
    output logic              cdb_src_out
);

    localparam int   PTR_W   = $clog2(DEPTH);
    localparam int   CNT_W   = $clog2(DEPTH + 1);
    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_LSU = 1'b1;

    // Index 0 is the ALU queue, index 1 the LSU queue, matching the cdb_src encoding.
    logic [ROB_W-1:0]  id_mem_q   [2][DEPTH];
    logic [DATA_W-1:0] data_mem_q [2][DEPTH];
    logic [PTR_W-1:0]  head_q [2];
    logic [PTR_W-1:0]  head_d [2];
    logic [PTR_W-1:0]  tail_q [2];
    logic [PTR_W-1:0]  tail_d [2];
    logic [CNT_W-1:0]  cnt_q  [2];
    logic [CNT_W-1:0]  cnt_d  [2];

    logic              last_grant_q, last_grant_d;
    logic              cdb_valid_q, cdb_valid_d;
    logic [ROB_W-1:0]  cdb_rob_id_q, cdb_rob_id_d;
    logic [DATA_W-1:0] cdb_result_q, cdb_result_d;
    logic              cdb_src_q, cdb_src_d;

    logic              in_valid  [2];
    logic [ROB_W-1:0]  in_id     [2];
    logic [DATA_W-1:0] in_data   [2];
    logic              ready     [2];
    logic              accept    [2];
    logic              from_q    [2];
    logic              cand      [2];
    logic [ROB_W-1:0]  cand_id   [2];
    logic [DATA_W-1:0] cand_data [2];
    logic              push      [2];
    logic              pop       [2];

    logic open_c;
    logic grant_any;
    logic grant_src;

    assign in_valid[0] = alu_valid_in;
    assign in_id[0]    = alu_rob_id_in;
    assign in_data[0]  = alu_result_in;
    assign in_valid[1] = lsu_valid_in;
    assign in_id[1]    = lsu_rob_id_in;
    assign in_data[1]  = lsu_result_in;

    assign open_c = rdy_in && !rollback_in;

    // The queue head always takes precedence over bypass so per-source order holds.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            ready[s]     = open_c && (cnt_q[s] < CNT_W'(DEPTH));
            accept[s]    = in_valid[s] && ready[s];
            from_q[s]    = (cnt_q[s] != '0);
            cand[s]      = from_q[s] || accept[s];
            cand_id[s]   = from_q[s] ? id_mem_q[s][head_q[s]]   : in_id[s];
            cand_data[s] = from_q[s] ? data_mem_q[s][head_q[s]] : in_data[s];
        end
    end

    assign alu_ready_out = ready[0];
    assign lsu_ready_out = ready[1];

    always_comb begin
        grant_any = open_c && (cand[0] || cand[1]);
        grant_src = SRC_ALU;
        if (cand[0] && cand[1]) begin
`ifdef CDB_ROUND_ROBIN_EN
            grant_src = ~last_grant_q;
`else
            grant_src = SRC_LSU;
`endif
        end else if (cand[1]) begin
            grant_src = SRC_LSU;
        end
    end

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            pop[s]  = grant_any && (grant_src == 1'(s)) && from_q[s];
            push[s] = accept[s] && !(grant_any && (grant_src == 1'(s)) && !from_q[s]);
            head_d[s] = head_q[s] + PTR_W'(pop[s]);
            tail_d[s] = tail_q[s] + PTR_W'(push[s]);
            cnt_d[s]  = cnt_q[s] + CNT_W'(push[s]) - CNT_W'(pop[s]);
            if (rollback_in) begin
                head_d[s] = '0;
                tail_d[s] = '0;
                cnt_d[s]  = '0;
            end
        end

        last_grant_d = last_grant_q;
        cdb_valid_d  = 1'b0;
        cdb_rob_id_d = cdb_rob_id_q;
        cdb_result_d = cdb_result_q;
        cdb_src_d    = cdb_src_q;
        if (grant_any) begin
            cdb_valid_d  = 1'b1;
            cdb_rob_id_d = cand_id[grant_src];
            cdb_result_d = cand_data[grant_src];
            cdb_src_d    = grant_src;
            last_grant_d = grant_src;
        end
    end

    // Queue storage carries no reset; occupancy is tracked by the counters alone.
    always_ff @(posedge clk_in) begin
        for (int s = 0; s < 2; s++) begin
            if (push[s]) begin
                id_mem_q[s][tail_q[s]]   <= in_id[s];
                data_mem_q[s][tail_q[s]] <= in_data[s];
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int s = 0; s < 2; s++) begin
                head_q[s] <= '0;
                tail_q[s] <= '0;
                cnt_q[s]  <= '0;
            end
            last_grant_q <= SRC_LSU;
            cdb_valid_q  <= 1'b0;
            cdb_rob_id_q <= '0;
            cdb_result_q <= '0;
            cdb_src_q    <= SRC_ALU;
        end else begin
            for (int s = 0; s < 2; s++) begin
                head_q[s] <= head_d[s];
                tail_q[s] <= tail_d[s];
                cnt_q[s]  <= cnt_d[s];
            end
            last_grant_q <= last_grant_d;
            cdb_valid_q  <= cdb_valid_d;
            cdb_rob_id_q <= cdb_rob_id_d;
            cdb_result_q <= cdb_result_d;
            cdb_src_q    <= cdb_src_d;
        end
    end

    assign cdb_valid_out  = cdb_valid_q;
    assign cdb_rob_id_out = cdb_rob_id_q;
    assign cdb_result_out = cdb_result_q;
    assign cdb_src_out    = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus random traffic against a queue-based reference model.
module tb_cdb_arbiter;

    localparam int ROB_W  = 4;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 2;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              rdy_in;
    logic              rollback_in;
    logic              alu_valid_in;
    logic [ROB_W-1:0]  alu_rob_id_in;
    logic [DATA_W-1:0] alu_result_in;
    logic              alu_ready_out;
    logic              lsu_valid_in;
    logic [ROB_W-1:0]  lsu_rob_id_in;
    logic [DATA_W-1:0] lsu_result_in;
    logic              lsu_ready_out;
    logic              cdb_valid_out;
    logic [ROB_W-1:0]  cdb_rob_id_out;
    logic [DATA_W-1:0] cdb_result_out;
    logic              cdb_src_out;

    cdb_arbiter #(.ROB_W(ROB_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .rollback_in    (rollback_in),
        .alu_valid_in   (alu_valid_in),
        .alu_rob_id_in  (alu_rob_id_in),
        .alu_result_in  (alu_result_in),
        .alu_ready_out  (alu_ready_out),
        .lsu_valid_in   (lsu_valid_in),
        .lsu_rob_id_in  (lsu_rob_id_in),
        .lsu_result_in  (lsu_result_in),
        .lsu_ready_out  (lsu_ready_out),
        .cdb_valid_out  (cdb_valid_out),
        .cdb_rob_id_out (cdb_rob_id_out),
        .cdb_result_out (cdb_result_out),
        .cdb_src_out    (cdb_src_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [ROB_W-1:0]  id;
        logic [DATA_W-1:0] d;
    } ent_t;

    // Reference model: each source is a plain FIFO of pending results.
    ent_t              aq[$];
    ent_t              lq[$];
    logic              m_last;
    logic              exp_ra, exp_rl, exp_v, exp_src;
    logic [ROB_W-1:0]  exp_id;
    logic [DATA_W-1:0] exp_d;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic va, input logic [ROB_W-1:0] ia, input logic [DATA_W-1:0] da,
                        input logic vl, input logic [ROB_W-1:0] il, input logic [DATA_W-1:0] dl,
                        input logic rdy, input logic rb);
        ent_t e;
        logic have;
        logic win;
        alu_valid_in  = va;
        alu_rob_id_in = ia;
        alu_result_in = da;
        lsu_valid_in  = vl;
        lsu_rob_id_in = il;
        lsu_result_in = dl;
        rdy_in        = rdy;
        rollback_in   = rb;
        #1;
        exp_ra = rdy && !rb && (aq.size() < DEPTH);
        exp_rl = rdy && !rb && (lq.size() < DEPTH);
        chk("alu_ready", 64'(alu_ready_out), 64'(exp_ra));
        chk("lsu_ready", 64'(lsu_ready_out), 64'(exp_rl));

        exp_v = 1'b0;
        have  = 1'b1;
        win   = 1'b0;
        if (rb) begin
            aq.delete();
            lq.delete();
        end else if (rdy) begin
            if (va && exp_ra) aq.push_back(ent_t'{id: ia, d: da});
            if (vl && exp_rl) lq.push_back(ent_t'{id: il, d: dl});
            if (aq.size() > 0 && lq.size() > 0) begin
`ifdef CDB_ROUND_ROBIN_EN
                win = !m_last;
`else
                win = 1'b1;
`endif
            end else if (aq.size() > 0) win = 1'b0;
            else if (lq.size() > 0) win = 1'b1;
            else have = 1'b0;
            if (have) begin
                e = win ? lq.pop_front() : aq.pop_front();
                exp_v   = 1'b1;
                exp_id  = e.id;
                exp_d   = e.d;
                exp_src = win;
                m_last  = win;
            end
        end

        @(posedge clk_in);
        #1;
        chk("cdb_valid", 64'(cdb_valid_out), 64'(exp_v));
        if (exp_v) begin
            chk("cdb_rob_id", 64'(cdb_rob_id_out), 64'(exp_id));
            chk("cdb_result", 64'(cdb_result_out), 64'(exp_d));
            chk("cdb_src", 64'(cdb_src_out), 64'(exp_src));
        end
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        alu_valid_in = 1'b0;
        lsu_valid_in = 1'b0;
        rdy_in       = 1'b1;
        rollback_in  = 1'b0;
        rst_in       = 1'b1;
        #1;
        chk("rst_valid", 64'(cdb_valid_out), 64'(0));
        chk("rst_rob_id", 64'(cdb_rob_id_out), 64'(0));
        chk("rst_result", 64'(cdb_result_out), 64'(0));
        chk("rst_src", 64'(cdb_src_out), 64'(0));
        aq.delete();
        lq.delete();
        m_last = 1'b1;
        @(posedge clk_in);
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
    endtask

    initial begin
        alu_rob_id_in = '0;
        alu_result_in = '0;
        lsu_rob_id_in = '0;
        lsu_result_in = '0;
        do_reset();
        idle();

        // single uncontended ALU result, one-cycle latency and one-cycle pulse
        step(1'b1, 4'd3, 32'h1234, 1'b0, '0, '0, 1'b1, 1'b0);
        chk("single_tag", 64'(cdb_rob_id_out), 64'(3));
        chk("single_data", 64'(cdb_result_out), 64'(32'h1234));
        chk("single_src", 64'(cdb_src_out), 64'(0));
        idle();
        chk("single_gone", 64'(cdb_valid_out), 64'(0));

        // contention: both sources every cycle
        for (int i = 0; i < 6; i++)
            step(1'b1, 4'(1 + i), 32'hA000 + 32'(i), 1'b1, 4'(9 + i), 32'hB000 + 32'(i), 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) idle();

        // fill queues, then flush
        for (int i = 0; i < 3; i++)
            step(1'b1, 4'(4 + i), 32'hC000 + 32'(i), 1'b1, 4'(12 + i), 32'hD000 + 32'(i), 1'b1, 1'b0);
        step(1'b1, 4'd7, 32'hE7, 1'b1, 4'd8, 32'hE8, 1'b1, 1'b1);
        chk("flush_valid", 64'(cdb_valid_out), 64'(0));
        idle();
        idle();
        step(1'b1, 4'd2, 32'h2222, 1'b0, '0, '0, 1'b1, 1'b0);
        chk("post_flush_tag", 64'(cdb_rob_id_out), 64'(2));

        // pause with a queued ALU entry
        step(1'b1, 4'd5, 32'h5555, 1'b1, 4'd12, 32'hCCCC, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b1, 4'd6, 32'h6666, 1'b1, 4'd13, 32'hDDDD, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) idle();

        // reset in the middle of traffic
        step(1'b1, 4'd1, 32'h11, 1'b1, 4'd9, 32'h99, 1'b1, 1'b0);
        step(1'b1, 4'd2, 32'h22, 1'b1, 4'd10, 32'hAA, 1'b1, 1'b0);
        do_reset();
        idle();
        idle();

        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 4'($urandom), $urandom,
                 1'($urandom_range(0, 1)), 4'($urandom), $urandom,
                 1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 19) == 0));
        for (int i = 0; i < 5; i++) idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
